// File: rtl/router_pkt_src.sv
// Packet source for the 1x3 router: turns a command into header, payload and
// parity bytes on the router's byte-serial input, honouring busy, then idles.
module router_pkt_src #(
  parameter int GAP_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_addr,
  input  logic [5:0]       cmd_len,
  input  logic [7:0]       cmd_seed,
  input  logic             cmd_bad_parity,
  output logic [7:0]       pkt_data,
  output logic             pkt_valid,
  input  logic             busy,
  output logic             pkt_done,
  output logic             cmd_err,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         len_q, len_d;
  logic [7:0]         seed_q, seed_d;
  logic               bad_q, bad_d;
  logic [5:0]         k_q, k_d;
  logic [7:0]         acc_q, acc_d;
  logic [3:0]         gap_q, gap_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         acc_next;

  // Accumulator value once the currently driven payload byte is folded in.
  assign acc_next = acc_q ^ data_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    len_d   = len_q;
    seed_d  = seed_q;
    bad_d   = bad_q;
    k_d     = k_q;
    acc_d   = acc_q;
    gap_d   = gap_q;
    data_d  = data_q;
    valid_d = valid_q;
    ready_d = ready_q;
    count_d = count_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          len_d  = cmd_len;
          seed_d = cmd_seed;
          bad_d  = cmd_bad_parity;
          if (cmd_addr == 2'd3 || cmd_len == 6'd0) begin
            err_d = 1'b1;
          end else begin
            state_d = S_HEADER;
            data_d  = {cmd_len, cmd_addr};
            acc_d   = {cmd_len, cmd_addr};
            valid_d = 1'b1;
            ready_d = 1'b0;
          end
        end
      end
      S_HEADER: begin
        if (!busy) begin
          state_d = S_PAYLOAD;
          data_d  = seed_q;
          k_d     = 6'd0;
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          acc_d = acc_next;
          if (k_q == len_q - 6'd1) begin
            state_d = S_PARITY;
            valid_d = 1'b0;
            data_d  = bad_q ? ~acc_next : acc_next;
          end else begin
            k_d    = k_q + 6'd1;
            data_d = data_q + 8'd1;
          end
        end
      end
      S_PARITY: begin
        if (!busy) begin
          state_d = S_GAP;
          data_d  = 8'd0;
          done_d  = 1'b1;
          count_d = count_q + CNT_W'(1);
          gap_d   = 4'(GAP_CYCLES - 1);
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        data_d  = 8'd0;
        ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: non-blocking assignments throughout, so every register samples the
  // values from before the edge regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      seed_q  <= '0;
      bad_q   <= 1'b0;
      k_q     <= '0;
      acc_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      bad_q   <= bad_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      count_q <= count_d;
    end
  end

  assign cmd_ready = ready_q;
  assign pkt_data  = data_q;
  assign pkt_valid = valid_q;
  assign pkt_done  = done_q;
  assign cmd_err   = err_q;
  assign pkt_count = count_q;

endmodule

// File: tb/tb_router_pkt_src.sv
// Bench for router_pkt_src: a per-cycle slot queue model built from the
// packet rules, checked against the DUT on every negedge, plus directed pins.
module tb_router_pkt_src;

  localparam int GAP   = 3;
  localparam int CNT_W = 3;

  logic             clock = 1'b0;
  logic             resetn;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_addr = '0;
  logic [5:0]       cmd_len = '0;
  logic [7:0]       cmd_seed = '0;
  logic             cmd_bad_parity = 1'b0;
  logic [7:0]       pkt_data;
  logic             pkt_valid;
  logic             busy = 1'b0;
  logic             pkt_done;
  logic             cmd_err;
  logic [CNT_W-1:0] pkt_count;

  router_pkt_src #(.GAP_CYCLES(GAP), .CNT_W(CNT_W)) dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .cmd_bad_parity(cmd_bad_parity),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .busy(busy),
    .pkt_done(pkt_done), .cmd_err(cmd_err), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One slot = what every output must show during one clock cycle.
  typedef struct packed {
    logic       ready;
    logic       valid;
    logic       xmit;
    logic       done;
    logic       err;
    logic [7:0] data;
  } slot_t;

  function automatic slot_t mk(input logic r, input logic v, input logic x,
                               input logic d, input logic e, input logic [7:0] b);
    slot_t s;
    s.ready = r; s.valid = v; s.xmit = x; s.done = d; s.err = e; s.data = b;
    return s;
  endfunction

  function automatic logic [7:0] exp_parity(input logic [1:0] a, input logic [5:0] l,
                                            input logic [7:0] s, input logic b);
    logic [7:0] acc;
    acc = {l, a};
    for (int k = 0; k < int'(l); k++) acc ^= 8'(int'(s) + k);
    return b ? ~acc : acc;
  endfunction

  slot_t            cur = '{ready: 1'b1, default: '0};
  slot_t            q[$];
  logic [CNT_W-1:0] m_count = '0;

  // Model: the current slot repeats on a busy edge while a byte is offered,
  // a handshake expands the command into its full list of slots.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      m_count = '0;
    end else if (cur.xmit && busy) begin
      cur = cur;
    end else if (cur.ready && cmd_valid) begin
      if (cmd_addr == 2'd3 || cmd_len == 6'd0) begin
        cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      end else begin
        q.delete();
        cur = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, {cmd_len, cmd_addr});
        for (int k = 0; k < int'(cmd_len); k++)
          q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(int'(cmd_seed) + k)));
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                       exp_parity(cmd_addr, cmd_len, cmd_seed, cmd_bad_parity)));
        for (int g = 0; g < GAP; g++)
          q.push_back(mk(1'b0, 1'b0, 1'b0, g == 0, 1'b0, 8'h00));
      end
    end else if (q.size() != 0) begin
      cur = q.pop_front();
      if (cur.done) m_count = m_count + 1'b1;
    end else begin
      cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    end
  end

  always @(negedge clock) begin
    check("cmd_ready", 32'(cmd_ready), 32'(cur.ready));
    check("pkt_valid", 32'(pkt_valid), 32'(cur.valid));
    check("pkt_data",  32'(pkt_data),  32'(cur.data));
    check("pkt_done",  32'(pkt_done),  32'(cur.done));
    check("cmd_err",   32'(cmd_err),   32'(cur.err));
    check("pkt_count", 32'(pkt_count), 32'(m_count));
  end

  // Lengths of each run of cmd_ready low, as seen on the DUT.
  int run = 0;
  int runs[$];
  always @(negedge clock) begin
    if (!cmd_ready) run++;
    else if (run != 0) begin
      runs.push_back(run);
      run = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s,
                      input logic b, input bit hold);
    bit r;
    int n = 0;
    cmd_addr = a; cmd_len = l; cmd_seed = s; cmd_bad_parity = b; cmd_valid = 1'b1;
    forever begin
      r = cur.ready;
      tick();
      if (r) break;
      n++;
      if (n > 500) begin
        check("send_timeout", 32'(0), 32'(1));
        break;
      end
    end
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(cur.ready && q.size() == 0)) begin
      tick();
      n++;
      if (n > 500) begin
        check("idle_timeout", 32'(0), 32'(1));
        break;
      end
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] nom_b [5];
  logic       nom_v [5];

  initial begin
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #20;
    @(posedge clock);
    #3 resetn = 1'b1;
    tick();

    // Model pins: header and parity values worked out by hand.
    check("pin_parity_nominal", 32'(exp_parity(2'd1, 6'd3, 8'h10, 1'b0)), 32'h1E);
    check("pin_parity_inject",  32'(exp_parity(2'd2, 6'd1, 8'hFF, 1'b1)), 32'h06);
    check("pin_parity_wrap",    32'(exp_parity(2'd0, 6'd2, 8'hFF, 1'b0)), 32'hF7);

    // Nominal packet.
    nom_b[0] = 8'h0D; nom_b[1] = 8'h10; nom_b[2] = 8'h11; nom_b[3] = 8'h12; nom_b[4] = 8'h1E;
    nom_v[0] = 1'b1;  nom_v[1] = 1'b1;  nom_v[2] = 1'b1;  nom_v[3] = 1'b1;  nom_v[4] = 1'b0;
    send(2'd1, 6'd3, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("nominal_byte",  32'(pkt_data),  32'(nom_b[i]));
      check("nominal_valid", 32'(pkt_valid), 32'(nom_v[i]));
    end
    @(negedge clock);
    check("nominal_done",  32'(pkt_done),  32'(1));
    check("nominal_count", 32'(pkt_count), 32'(1));
    tick();
    wait_idle();

    // Busy stall on payload byte 8'h11.
    send(2'd1, 6'd3, 8'h10, 1'b0, 1'b0);
    tick();
    tick();
    busy = 1'b1;
    tick();
    tick();
    busy = 1'b0;
    @(negedge clock);
    check("stall_hold", 32'(pkt_data), 32'h11);
    tick();
    wait_idle();

    // Error injection, then payload wrap.
    send(2'd2, 6'd1, 8'hFF, 1'b1, 1'b0);
    @(negedge clock); check("inject_hdr", 32'(pkt_data), 32'h06);
    @(negedge clock); check("inject_pay", 32'(pkt_data), 32'hFF);
    @(negedge clock); check("inject_par", 32'(pkt_data), 32'h06);
    tick();
    wait_idle();
    send(2'd0, 6'd2, 8'hFF, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock); check("wrap_b0", 32'(pkt_data), 32'hFF);
    @(negedge clock); check("wrap_b1", 32'(pkt_data), 32'h00);
    tick();
    wait_idle();

    // Illegal commands.
    send(2'd3, 6'd4, 8'h55, 1'b0, 1'b0);
    @(negedge clock);
    check("illegal_addr_err", 32'(cmd_err), 32'(1));
    tick();
    send(2'd0, 6'd0, 8'h55, 1'b0, 1'b0);
    @(negedge clock);
    check("illegal_len_err", 32'(cmd_err), 32'(1));
    tick();
    wait_idle();
    check("illegal_count", 32'(pkt_count), 32'(4));

    // Reset during payload byte 2 of a len=8 packet.
    send(2'd1, 6'd8, 8'h20, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    #1 resetn = 1'b0;
    #1;
    check("rst_valid", 32'(pkt_valid), 32'(0));
    check("rst_data",  32'(pkt_data),  32'(0));
    check("rst_count", 32'(pkt_count), 32'(0));
    @(posedge clock);
    #3 resetn = 1'b1;
    tick();
    send(2'd2, 6'd5, 8'h40, 1'b0, 1'b0);
    wait_idle();

    // Back-to-back with cmd_valid held high.
    runs.delete();
    send(2'd0, 6'd3, 8'hA0, 1'b0, 1'b1);
    send(2'd1, 6'd3, 8'hB0, 1'b0, 1'b1);
    send(2'd2, 6'd3, 8'hC0, 1'b0, 1'b0);
    wait_idle();
    check("b2b_runs", 32'(runs.size()), 32'(3));
    foreach (runs[i]) check("b2b_gap", 32'(runs[i]), 32'(5 + GAP));

    // Randomized traffic with random busy.
    for (int c = 0; c < 3000; c++) begin
      bit r;
      busy = ($urandom_range(0, 99) < 30);
      if (!cmd_valid && $urandom_range(0, 99) < 20) begin
        int sel;
        sel = $urandom_range(0, 9);
        cmd_addr = 2'($urandom_range(0, 3));
        cmd_len = (sel == 0) ? 6'd0 : (sel == 1) ? 6'd63 : 6'($urandom_range(1, 8));
        cmd_seed = 8'($urandom_range(0, 255));
        cmd_bad_parity = 1'($urandom_range(0, 1));
        cmd_valid = 1'b1;
      end
      r = cur.ready;
      tick();
      if (r && cmd_valid) cmd_valid = 1'b0;
    end
    busy = 1'b0;
    cmd_valid = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
